gauss_kernel_gen: RTL and testbench
===================================

# gauss_kernel_gen

Parametrised successor to the team's Gaussian kernel builder. On a start strobe it generates a normalised, separable Gaussian kernel for a runtime-selected odd size and sigma. It drives a 1-D tap vector (sum exactly 2^COEF_W) and the full 2-D outer-product kernel to the blur/convolution stage ahead of the FAST detector. It replaces the fixed-width builder with configurable coefficient precision, exact normalisation, and explicit config error reporting.

## Interface
- MAX_KERNEL, 7: largest supported kernel side; odd, ≥3.
- COEF_W, 8: coefficient width; normalisation target 2^COEF_W.
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request build; sampled only in IDLE.
- sigma  in  3  Gaussian sigma 1..7; 0 invalid.
- kernel_size  in  $clog2(MAX_KERNEL+1)  side length; odd, 3..MAX_KERNEL.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when outputs are valid.
- err  out  1  one-cycle pulse on rejected config.
- size_q  out  $clog2(MAX_KERNEL+1)  latched size of the current/last kernel.
- taps  out  [MAX_KERNEL-1:0][COEF_W-1:0]  1-D coefficients at indices 0..size_q-1; higher indices 0.
- kernel  out  [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0]  2-D kernel at [r][c], r,c<size_q; others 0.

## Operation
- Reset values: busy 0, done 0, err 0, size_q 0, taps all 0, kernel all 0, state IDLE.
- Raw weight ROM: raw(σ,d) = round(255·exp(−d²/(2σ²))), 8 bits, for d = 0..(MAX_KERNEL−1)/2. Contents are fixed at elaboration.
- States: IDLE → LOAD → DIV → FIXUP → OUTER → DONE → IDLE.
- IDLE, start=1:
  - If sigma=0, kernel_size even, <3 or >MAX_KERNEL: pulse err next cycle, stay IDLE, leave all outputs unchanged.
  - Otherwise latch sigma and size (size_q updates), clear taps/kernel to 0, go to LOAD.
- LOAD: h=(size−1)/2. Reads raw(σ,d) for d=0..h, one per cycle (h+1 cycles).
  - sum = raw(0) + 2·Σ raw(1..h).
  - Sum width is 8+$clog2(MAX_KERNEL) bits, no overflow.
- DIV: for each d=0..h, q(d) = floor(raw(d)·2^COEF_W / sum).
  - Restoring divider, one quotient bit per cycle, COEF_W cycles per d.
  - q(d) < 2^COEF_W is guaranteed for size ≥3.
  - Writes taps[h−d] and taps[h+d].
- FIXUP (1 cycle): rem = 2^COEF_W − Σ taps. Added to centre tap taps[h], so Σ taps = 2^COEF_W exactly.
- OUTER: one row r per cycle (size cycles). kernel[r][c] = (taps[r]·taps[c] + 2^(COEF_W−1)) >> COEF_W for c<size.
- DONE: done=1 for one cycle, then IDLE. Outputs hold until the next accepted start or reset.
- start while busy is ignored (not queued). sigma/kernel_size changes while busy have no effect.
- Reset mid-build: immediate return to reset values; no done/err.

## Timing
- Accepted start sampled at edge E0; done is high in the cycle after edge E0 + N, where N = (h+1)(COEF_W+1) + size + 2.
  - size 3, COEF_W 8: N = 23.
  - size 7, COEF_W 8: N = 45.
- busy rises the cycle after E0 and falls with done (low in the cycle after done).
- err is high exactly one cycle, the cycle after the sampling edge. busy stays 0.
- start may be re-asserted in the cycle done is high; it is sampled at the following edge in IDLE.
- taps final values are stable from the end of FIXUP; kernel rows fill progressively during OUTER; both are guaranteed only when done=1.

## Test plan
- Reset: n_rst low for 2 cycles with start=1 → all outputs 0, no done/err.
- size 3, σ1, COEF_W 8 → taps = {70,116,70}, sum 256; kernel corners 19, edges 32, centre 53; done after exactly 23 cycles.
- size 3, σ2 → raw {225,255,225}, sum 705; taps = {81,94,81}; done pulse one cycle, busy drops with it.
- Invalid configs, one start each: σ0/size3; σ1/size4; σ1/size1; σ1/size9 (MAX 7) → err one-cycle pulse each. No busy, and taps/kernel retain the prior valid kernel.
- size 7, σ3: check Σ taps = 256, symmetry taps[i]=taps[6−i], kernel symmetric, done at N=45. start pulses during busy are ignored.
- Reset asserted mid-DIV → outputs zero immediately; a following valid start completes normally with correct values.

Source files
------------

// File: rtl/gauss_kernel_gen.sv
// Builds a normalised separable Gaussian kernel (1-D taps summing to 2^COEF_W and
// the rounded 2-D outer product) for a runtime-selected odd size and sigma.
module gauss_kernel_gen #(
    parameter int unsigned MAX_KERNEL = 7,
    parameter int unsigned COEF_W     = 8
) (
    input  logic                                              clk,
    input  logic                                              n_rst,
    input  logic                                              start,
    input  logic [2:0]                                        sigma,
    input  logic [$clog2(MAX_KERNEL+1)-1:0]                   kernel_size,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err,
    output logic [$clog2(MAX_KERNEL+1)-1:0]                   size_q,
    output logic [MAX_KERNEL-1:0][COEF_W-1:0]                 taps,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] kernel
);

    localparam int unsigned SW    = $clog2(MAX_KERNEL + 1);
    localparam int unsigned HM    = (MAX_KERNEL - 1) / 2;
    localparam int unsigned SUM_W = 8 + $clog2(MAX_KERNEL);
    localparam int unsigned BW    = (COEF_W > 1) ? $clog2(COEF_W) : 1;
    localparam int unsigned TS_W  = COEF_W + SW;
    localparam int unsigned PW    = 2 * COEF_W + 1;
    localparam int unsigned ROM_W = 8 * 8 * (HM + 1);
    localparam int unsigned RI_W  = $clog2(ROM_W);
    localparam logic [SW:0]   MAX_S = (SW+1)'(MAX_KERNEL);
    localparam logic [PW-1:0] RND   = PW'(1) << (COEF_W - 1);

    // exp(-1/(2s^2)) by series in Q30, raised to d^2 by repeated multiplication.
    function automatic logic [7:0] raw_weight(input int unsigned sig, input int unsigned d);
        longint base, term, val, den;
        if (sig == 0) return 8'd0;
        den  = longint'(2 * sig * sig);
        base = longint'(1) <<< 30;
        term = base;
        for (int unsigned k = 1; k < 24; k++) begin
            term = -term / (den * longint'(k));
            base = base + term;
        end
        val = longint'(1) <<< 30;
        for (int unsigned i = 0; i < d * d; i++) val = (val * base) >>> 30;
        val = (val * 64'sd255 + (longint'(1) <<< 29)) >>> 30;
        return val[7:0];
    endfunction

    function automatic logic [ROM_W-1:0] build_rom();
        logic [ROM_W-1:0] r;
        r = '0;
        for (int unsigned s = 1; s < 8; s++)
            for (int unsigned d = 0; d <= HM; d++)
                r[(s * (HM + 1) + d) * 8 +: 8] = raw_weight(s, d);
        return r;
    endfunction

    localparam logic [ROM_W-1:0] RAW_ROM = build_rom();

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DIV, ST_FIXUP, ST_OUTER, ST_DONE} state_t;

    state_t                                            state_q, state_d;
    logic [2:0]                                        sig_q, sig_d;
    logic [SW-1:0]                                     size_d, idx_q, idx_d, half;
    logic [BW-1:0]                                     bit_q, bit_d;
    logic [SUM_W-1:0]                                  sum_q, sum_d, rem_q, rem_d;
    logic [COEF_W-1:0]                                 quo_q, quo_d;
    logic [MAX_KERNEL-1:0][COEF_W-1:0]                 taps_q, taps_d;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] kernel_q, kernel_d;
    logic                                              done_q, done_d, err_q, err_d;

    logic              cfg_ok, ge;
    logic [RI_W-1:0]   rom_idx;
    logic [7:0]        raw;
    logic [SUM_W-1:0]  div_base, rem_next;
    logic [SUM_W:0]    shifted;
    logic [COEF_W-1:0] quo_next;
    logic [TS_W-1:0]   tap_sum, fix;

    assign half   = (size_q - SW'(1)) >> 1;
    assign cfg_ok = (sigma != 3'd0) && kernel_size[0] && (kernel_size >= SW'(3)) &&
                    ({1'b0, kernel_size} <= MAX_S);

    // Restoring divider: raw < sum, so the remainder seeds with raw and each step yields one quotient bit.
    always_comb begin
        rom_idx  = RI_W'((32'(sig_q) * (HM + 1) + 32'(idx_q)) * 8);
        raw      = RAW_ROM[rom_idx +: 8];
        div_base = (bit_q == '0) ? SUM_W'(raw) : rem_q;
        shifted  = {div_base, 1'b0};
        ge       = shifted >= {1'b0, sum_q};
        rem_next = ge ? SUM_W'(shifted - {1'b0, sum_q}) : SUM_W'(shifted);
        quo_next = (quo_q << 1) | COEF_W'(ge);
        tap_sum  = '0;
        for (int unsigned i = 0; i < MAX_KERNEL; i++) tap_sum = tap_sum + TS_W'(taps_q[SW'(i)]);
        fix      = (TS_W'(1) << COEF_W) - tap_sum;
    end

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        size_d   = size_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        sum_d    = sum_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        taps_d   = taps_q;
        kernel_d = kernel_q;
        done_d   = (state_q == ST_DONE);
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        sig_d    = sigma;
                        size_d   = kernel_size;
                        taps_d   = '0;
                        kernel_d = '0;
                        sum_d    = '0;
                        idx_d    = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                sum_d = sum_q + ((idx_q == '0) ? SUM_W'(raw) : (SUM_W'(raw) << 1));
                if (idx_q == half) begin
                    idx_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DIV;
                end else begin
                    idx_d = idx_q + SW'(1);
                end
            end
            ST_DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (bit_q == BW'(COEF_W - 1)) begin
                    taps_d[half - idx_q] = quo_next;
                    taps_d[half + idx_q] = quo_next;
                    bit_d = '0;
                    if (idx_q == half) state_d = ST_FIXUP;
                    else               idx_d   = idx_q + SW'(1);
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            ST_FIXUP: begin
                taps_d[half] = taps_q[half] + COEF_W'(fix);
                idx_d        = '0;
                state_d      = ST_OUTER;
            end
            ST_OUTER: begin
                for (int unsigned c = 0; c < MAX_KERNEL; c++)
                    kernel_d[idx_q][SW'(c)] =
                        COEF_W'((PW'(taps_q[idx_q]) * PW'(taps_q[SW'(c)]) + RND) >> COEF_W);
                if (idx_q == size_q - SW'(1)) state_d = ST_DONE;
                else                          idx_d   = idx_q + SW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            sig_q    <= '0;
            size_q   <= '0;
            idx_q    <= '0;
            bit_q    <= '0;
            sum_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            taps_q   <= '0;
            kernel_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            size_q   <= size_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            sum_q    <= sum_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            taps_q   <= taps_d;
            kernel_q <= kernel_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // done is registered off DONE, so busy is held through the done cycle.
    assign busy   = (state_q != ST_IDLE) || done_q;
    assign done   = done_q;
    assign err    = err_q;
    assign taps   = taps_q;
    assign kernel = kernel_q;

endmodule

// File: tb/tb_gauss_kernel_gen.sv
// Directed bench for gauss_kernel_gen (MAX_KERNEL 7, COEF_W 8) with hand-computed taps.
module tb_gauss_kernel_gen;

    typedef logic [6:0][7:0]      taps_t;
    typedef logic [6:0][6:0][7:0] kern_t;

    typedef struct {
        logic [2:0] sigma;
        logic [2:0] ksize;
        bit         is_err;
        logic [2:0] exp_size;
        taps_t      exp_taps;
        int         lat;
        bit         poke;
        bit         chain;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst, start;
    logic [2:0] sigma, kernel_size, size_q;
    logic       busy, done, err;
    taps_t      taps;
    kern_t      kernel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gauss_kernel_gen #(.MAX_KERNEL(7), .COEF_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .sigma(sigma), .kernel_size(kernel_size),
        .busy(busy), .done(done), .err(err), .size_q(size_q), .taps(taps), .kernel(kernel)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic kern_t kmodel(input taps_t t);
        kern_t k;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                k[r][c] = 8'((int'(t[r]) * int'(t[c]) + 128) >> 8);
        return k;
    endfunction

    task automatic run_vec(input vec_t v, input bit pre, input vec_t nx);
        int    cyc;
        kern_t ek;
        ek = kmodel(v.exp_taps);
        if (!pre) begin
            @(negedge clk);
            sigma = v.sigma; kernel_size = v.ksize; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        if (v.is_err) begin
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_done", done, 0);
            @(posedge clk); #1;
            chk("err_clear", err, 0);
            chk("err_busy_after", busy, 0);
            chk("err_taps_kept", taps, v.exp_taps);
            chk("err_kernel_kept", kernel, ek);
            chk("err_size_kept", size_q, v.exp_size);
        end else begin
            chk("busy_rise", busy, 1);
            chk("taps_cleared", taps, 0);
            chk("size_latch", size_q, v.exp_size);
            while (done !== 1'b1 && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
                if (v.poke) begin
                    start = (cyc == 1 || cyc == 20 || cyc == 44);
                    sigma = 3'd1; kernel_size = 3'd3;
                end
            end
            chk("latency", cyc, v.lat);
            chk("taps", taps, v.exp_taps);
            chk("kernel", kernel, ek);
            chk("size_done", size_q, v.exp_size);
            chk("busy_with_done", busy, 1);
            chk("no_err", err, 0);
            if (v.chain) begin
                sigma = nx.sigma; kernel_size = nx.ksize; start = 1'b1;
            end else begin
                @(posedge clk); #1;
                chk("done_one_cycle", done, 0);
                chk("busy_fall", busy, 0);
            end
        end
    endtask

    localparam int NV = 9;
    vec_t tbl [NV];
    vec_t mid;

    initial begin
        //           sigma ksize err size taps (index 0 rightmost)                                        lat poke chain
        tbl[0] = '{3'd1, 3'd3, 1'b0, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd70,8'd116,8'd70},                    23, 1'b0, 1'b0};
        tbl[1] = '{3'd2, 3'd3, 1'b0, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd81,8'd94,8'd81},                     23, 1'b0, 1'b0};
        tbl[2] = '{3'd0, 3'd3, 1'b1, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd81,8'd94,8'd81},                      0, 1'b0, 1'b0};
        tbl[3] = '{3'd1, 3'd4, 1'b1, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd81,8'd94,8'd81},                      0, 1'b0, 1'b0};
        tbl[4] = '{3'd1, 3'd1, 1'b1, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd81,8'd94,8'd81},                      0, 1'b0, 1'b0};
        // a 9 is not representable on a 3-bit size port; 0 is the out-of-range case here
        tbl[5] = '{3'd1, 3'd0, 1'b1, 3'd3, {8'd0,8'd0,8'd0,8'd0,8'd81,8'd94,8'd81},                      0, 1'b0, 1'b0};
        tbl[6] = '{3'd3, 3'd7, 1'b0, 3'd7, {8'd27,8'd35,8'd42,8'd48,8'd42,8'd35,8'd27},                 45, 1'b1, 1'b0};
        tbl[7] = '{3'd1, 3'd7, 1'b0, 3'd7, {8'd1,8'd13,8'd61,8'd106,8'd61,8'd13,8'd1},                  45, 1'b0, 1'b1};
        tbl[8] = '{3'd7, 3'd5, 1'b0, 3'd5, {8'd0,8'd0,8'd50,8'd51,8'd54,8'd51,8'd50},                   34, 1'b0, 1'b0};

        n_rst = 1'b0; start = 1'b1; sigma = 3'd1; kernel_size = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_size", size_q, 0);
        chk("rst_taps", taps, 0);
        chk("rst_kernel", kernel, 0);
        @(negedge clk);
        start = 1'b0;
        n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(tbl[i], (i > 0) && tbl[(i > 0) ? i - 1 : 0].chain, tbl[(i + 1 < NV) ? i + 1 : i]);
        end

        // reset in the middle of the divide phase
        @(negedge clk);
        sigma = 3'd2; kernel_size = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_size_latched", size_q, 3);
        repeat (6) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_size", size_q, 0);
        chk("mid_rst_taps", taps, 0);
        chk("mid_rst_kernel", kernel, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done, 0);
        chk("mid_rst_no_err", err, 0);
        @(negedge clk);
        n_rst = 1'b1;
        mid = tbl[0];
        run_vec(mid, 1'b0, mid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
